// File: rtl/messbauer_channel_sequencer.sv
// ============================================================================
// Module   : messbauer_channel_sequencer
// Brief    : Start pulse / channel clock timing source for the Messbauer sweep.
//            Optional sweep counter enabled by MESSBAUER_CYCLE_COUNTER_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module messbauer_channel_sequencer #(
  parameter int CHANNEL_HALF_PERIOD = 6400,
  parameter int CHANNEL_COUNT       = 4096,
  parameter int START_PULSE_LEN     = 4
) (
  input  logic        aclk,
  input  logic        areset,
  input  logic        enable,
  output logic        start,
  output logic        channel,
  output logic [11:0] channel_index,
  output logic        reverse,
  output logic        cycle_done,
`ifdef MESSBAUER_CYCLE_COUNTER_EN
  output logic [15:0] cycle_count,
`endif
  output logic        busy
);

  localparam int PW  = (CHANNEL_HALF_PERIOD > 1) ? $clog2(CHANNEL_HALF_PERIOD) : 1;
  localparam int PCW = (START_PULSE_LEN > 1) ? $clog2(START_PULSE_LEN) : 1;

  localparam logic [PW-1:0]  PRESC_LAST = PW'(CHANNEL_HALF_PERIOD - 1);
  localparam logic [PCW-1:0] PULSE_LAST = PCW'(START_PULSE_LEN - 1);
  localparam logic [11:0]    INDEX_LAST = 12'(CHANNEL_COUNT - 1);
  localparam logic [11:0]    INDEX_HALF = 12'(CHANNEL_COUNT / 2);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_RUN   = 2'd2
  } state_t;

  state_t         state_q, state_d;
  logic           start_q, start_d;
  logic           channel_q, channel_d;
  logic [11:0]    index_q, index_d;
  logic           reverse_q, reverse_d;
  logic           done_q, done_d;
  logic           busy_q, busy_d;
  logic [PW-1:0]  presc_q, presc_d;
  logic [PCW-1:0] pulse_q, pulse_d;

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      state_q   <= S_IDLE;
      start_q   <= 1'b0;
      channel_q <= 1'b1;
      index_q   <= 12'd0;
      reverse_q <= 1'b0;
      done_q    <= 1'b0;
      busy_q    <= 1'b0;
      presc_q   <= '0;
      pulse_q   <= '0;
    end else begin
      state_q   <= state_d;
      start_q   <= start_d;
      channel_q <= channel_d;
      index_q   <= index_d;
      reverse_q <= reverse_d;
      done_q    <= done_d;
      busy_q    <= busy_d;
      presc_q   <= presc_d;
      pulse_q   <= pulse_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    start_d   = start_q;
    channel_d = channel_q;
    index_d   = index_q;
    done_d    = 1'b0;
    busy_d    = busy_q;
    presc_d   = presc_q;
    pulse_d   = pulse_q;

    case (state_q)
      S_IDLE: begin
        channel_d = 1'b1;
        start_d   = 1'b0;
        busy_d    = 1'b0;
        if (enable) begin
          state_d = S_START;
          start_d = 1'b1;
          busy_d  = 1'b1;
          pulse_d = '0;
          index_d = 12'd0;
        end
      end

      S_START: begin
        channel_d = 1'b1;
        index_d   = 12'd0;
        if (pulse_q == PULSE_LAST) begin
          state_d = S_RUN;
          start_d = 1'b0;
          presc_d = '0;
        end else begin
          pulse_d = pulse_q + 1'b1;
        end
      end

      S_RUN: begin
        if (presc_q == PRESC_LAST) begin
          presc_d   = '0;
          channel_d = ~channel_q;
          // A low channel about to toggle is the rising edge that closes a channel.
          if (!channel_q) begin
            if (index_q == INDEX_LAST) begin
              index_d = 12'd0;
              done_d  = 1'b1;
              if (enable) begin
                state_d = S_START;
                start_d = 1'b1;
                pulse_d = '0;
              end else begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
              end
            end else begin
              index_d = index_q + 12'd1;
            end
          end
        end else begin
          presc_d = presc_q + 1'b1;
        end
      end

      default: begin
        state_d   = S_IDLE;
        start_d   = 1'b0;
        channel_d = 1'b1;
        index_d   = 12'd0;
        busy_d    = 1'b0;
      end
    endcase

    // Compare on the next index so reverse moves on the same clock as the index.
    reverse_d = (index_d >= INDEX_HALF);
  end

`ifdef MESSBAUER_CYCLE_COUNTER_EN
  logic [15:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (done_d && (count_q != 16'hFFFF)) begin
      count_d = count_q + 16'd1;
    end
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      count_q <= 16'd0;
    end else begin
      count_q <= count_d;
    end
  end

  assign cycle_count = count_q;
`endif

  assign start         = start_q;
  assign channel       = channel_q;
  assign channel_index = index_q;
  assign reverse       = reverse_q;
  assign cycle_done    = done_q;
  assign busy          = busy_q;

endmodule

`default_nettype wire

// File: tb/tb_messbauer_channel_sequencer.sv
// ============================================================================
// Module   : tb_messbauer_channel_sequencer
// Brief    : Directed self-checking bench for messbauer_channel_sequencer.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_messbauer_channel_sequencer;

  localparam int H     = 4;
  localparam int C     = 8;
  localparam int L     = 2;
  localparam int SWEEP = L + 2 * H * C;  // 66

  logic        aclk = 1'b0;
  logic        areset;
  logic        enable;
  logic        start;
  logic        channel;
  logic [11:0] channel_index;
  logic        reverse;
  logic        cycle_done;
  logic        busy;
`ifdef MESSBAUER_CYCLE_COUNTER_EN
  logic [15:0] cycle_count;
`endif

  int checks = 0;
  int errors = 0;

  always #5 aclk = ~aclk;

  messbauer_channel_sequencer #(
    .CHANNEL_HALF_PERIOD(H),
    .CHANNEL_COUNT      (C),
    .START_PULSE_LEN    (L)
  ) dut (
    .aclk         (aclk),
    .areset       (areset),
    .enable       (enable),
    .start        (start),
    .channel      (channel),
    .channel_index(channel_index),
    .reverse      (reverse),
    .cycle_done   (cycle_done),
`ifdef MESSBAUER_CYCLE_COUNTER_EN
    .cycle_count  (cycle_count),
`endif
    .busy         (busy)
  );

  // Packed observation: {start, channel, index[11:0], reverse, cycle_done, busy}
  logic [16:0] obs;
  assign obs = {start, channel, channel_index, reverse, cycle_done, busy};

  localparam logic [16:0] RESET_VEC = {1'b0, 1'b1, 12'd0, 1'b0, 1'b0, 1'b0};

  // Expected outputs k edges after the edge where start rose; cont says whether
  // enable is high at the end-of-sweep decision.
  function automatic logic [16:0] model(input int k, input bit cont);
    int r;
    int idx;
    if (k == SWEEP)
      return {cont, 1'b1, 12'd0, 1'b0, 1'b1, cont};
    if (k < L)
      return {1'b1, 1'b1, 12'd0, 1'b0, 1'b0, 1'b1};
    r   = k - L;
    idx = r / (2 * H);
    return {1'b0, ((r % (2 * H)) < H), 12'(idx), (idx >= C / 2), 1'b0, 1'b1};
  endfunction

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  task automatic test_reset();
    areset = 1'b1;
    enable = 1'b0;
    repeat (3) tick();
    checks++;
    if (obs !== RESET_VEC) begin
      errors++;
      $display("FAIL reset_hold: got %h expected %h", obs, RESET_VEC);
    end
    areset = 1'b0;
    repeat (5) tick();
    checks++;
    if (obs !== RESET_VEC) begin
      errors++;
      $display("FAIL reset_idle: got %h expected %h", obs, RESET_VEC);
    end
  endtask

  task automatic test_single_sweep();
    logic [16:0] e;
    enable = 1'b1;
    tick();
    enable = 1'b0;
    for (int k = 0; k <= SWEEP; k++) begin
      if (k > 0) tick();
      e = model(k, 1'b0);
      checks++;
      if (obs !== e) begin
        errors++;
        $display("FAIL single_sweep k=%0d: got %h expected %h", k, obs, e);
      end
    end
    repeat (4) tick();
    checks++;
    if (obs !== RESET_VEC) begin
      errors++;
      $display("FAIL single_after_idle: got %h expected %h", obs, RESET_VEC);
    end
  endtask

  task automatic test_continuous();
    logic [16:0] e;
    enable = 1'b1;
    tick();
    for (int k = 0; k <= SWEEP; k++) begin
      if (k > 0) tick();
      e = model(k, 1'b1);
      checks++;
      if (obs !== e) begin
        errors++;
        $display("FAIL continuous_first k=%0d: got %h expected %h", k, obs, e);
      end
    end
    // The edge that pulsed cycle_done is edge 0 of the second sweep.
    for (int k = 1; k <= SWEEP; k++) begin
      tick();
      if (k == 1) enable = 1'b0;
      e = model(k, 1'b0);
      checks++;
      if (obs !== e) begin
        errors++;
        $display("FAIL continuous_second k=%0d: got %h expected %h", k, obs, e);
      end
    end
    repeat (3) tick();
    checks++;
    if (obs !== RESET_VEC) begin
      errors++;
      $display("FAIL continuous_idle: got %h expected %h", obs, RESET_VEC);
    end
  endtask

  task automatic test_early_disable();
    logic [16:0] e;
    enable = 1'b1;
    tick();
    for (int k = 0; k <= SWEEP; k++) begin
      if (k > 0) tick();
      if (k == L + 3 * 2 * H) enable = 1'b0;  // index just became 3
      e = model(k, 1'b0);
      checks++;
      if (obs !== e) begin
        errors++;
        $display("FAIL early_disable k=%0d: got %h expected %h", k, obs, e);
      end
    end
    repeat (6) tick();
    checks++;
    if (obs !== RESET_VEC) begin
      errors++;
      $display("FAIL early_disable_idle: got %h expected %h", obs, RESET_VEC);
    end
  endtask

  task automatic test_mid_sweep_reset();
    logic [16:0] e;
    enable = 1'b1;
    tick();
    enable = 1'b0;
    for (int k = 1; k <= L + 5 * 2 * H; k++) tick();
    e = model(L + 5 * 2 * H, 1'b0);
    checks++;
    if (obs !== e) begin
      errors++;
      $display("FAIL mid_reset_pre: got %h expected %h", obs, e);
    end
    #2 areset = 1'b1;
    #1;
    checks++;
    if (obs !== RESET_VEC) begin
      errors++;
      $display("FAIL mid_reset_async: got %h expected %h", obs, RESET_VEC);
    end
    #1 areset = 1'b0;
    enable = 1'b1;
    tick();
    enable = 1'b0;
    for (int k = 0; k <= SWEEP; k++) begin
      if (k > 0) tick();
      e = model(k, 1'b0);
      checks++;
      if (obs !== e) begin
        errors++;
        $display("FAIL mid_reset_resweep k=%0d: got %h expected %h", k, obs, e);
      end
    end
  endtask

`ifdef MESSBAUER_CYCLE_COUNTER_EN
  task automatic test_cycle_counter();
    int waited;
    areset = 1'b1;
    tick();
    areset = 1'b0;
    checks++;
    if (cycle_count !== 16'd0) begin
      errors++;
      $display("FAIL count_reset: got %0d expected 0", cycle_count);
    end
    enable = 1'b1;
    for (int n = 1; n <= 3; n++) begin
      waited = 0;
      do begin
        tick();
        waited++;
      end while (cycle_done !== 1'b1 && waited < 4 * SWEEP);
      checks++;
      if (cycle_done !== 1'b1 || cycle_count !== 16'(n)) begin
        errors++;
        $display("FAIL count_sweep%0d: done=%b count=%0d expected done=1 count=%0d",
                 n, cycle_done, cycle_count, n);
      end
    end
    enable = 1'b0;
    repeat (3) tick();
    areset = 1'b1;
    #1;
    checks++;
    if (cycle_count !== 16'd0) begin
      errors++;
      $display("FAIL count_clear: got %0d expected 0", cycle_count);
    end
    tick();
    areset = 1'b0;
  endtask
`endif

  initial begin
    areset = 1'b1;
    enable = 1'b0;
    test_reset();
    test_single_sweep();
    test_continuous();
    test_early_disable();
    test_mid_sweep_reset();
`ifdef MESSBAUER_CYCLE_COUNTER_EN
    test_cycle_counter();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
